// File: rtl/sar_logic.sv
// Successive-approximation controller: sample phase, MSB-first comparator trials
// with a per-trial timeout, and result capture for the capacitor driver.
module sar_logic #(
    parameter int NBITS         = 16,
    parameter int SAMPLE_CYCLES = 2,
    parameter int COMP_TIMEOUT  = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             invert_en_i,
    output logic             comp_req_o,
    input  logic             comp_valid_i,
    input  logic             comp_out_i,
    output logic             sample_o,
    output logic [NBITS-1:0] dac_state_o,
    output logic             dac_drive_invert_o,
    output logic             busy_o,
    output logic [NBITS-1:0] result_o,
    output logic             result_valid_o,
    output logic             timeout_err_o
);

    localparam int CNT_MAX = (SAMPLE_CYCLES > COMP_TIMEOUT) ? SAMPLE_CYCLES : COMP_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_COMPARE,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    idx_m1;
    logic [NBITS-1:0] dac_q, dac_d;
    logic [NBITS-1:0] res_q, res_d;
    logic             inv_q, inv_d;
    logic             busy_q, busy_d;
    logic             sample_q, sample_d;
    logic             req_q, req_d;
    logic             rv_q, rv_d;
    logic             to_q, to_d;
    logic             decide;
    logic             bit_val;

    assign idx_m1 = idx_q - 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= IW'(NBITS - 1);
            dac_q    <= '0;
            res_q    <= '0;
            inv_q    <= 1'b0;
            busy_q   <= 1'b0;
            sample_q <= 1'b0;
            req_q    <= 1'b0;
            rv_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dac_q    <= dac_d;
            res_q    <= res_d;
            inv_q    <= inv_d;
            busy_q   <= busy_d;
            sample_q <= sample_d;
            req_q    <= req_d;
            rv_q     <= rv_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dac_d    = dac_q;
        res_d    = res_q;
        inv_d    = inv_q;
        busy_d   = busy_q;
        sample_d = sample_q;
        req_d    = 1'b0;
        rv_d     = 1'b0;
        to_d     = to_q;
        decide   = 1'b0;
        bit_val  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A start landing in the result_valid cycle is deliberately dropped.
                if (start_i && !rv_q) begin
                    state_d  = S_SAMPLE;
                    inv_d    = invert_en_i;
                    dac_d    = '0;
                    to_d     = 1'b0;
                    busy_d   = 1'b1;
                    sample_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
                    sample_d = 1'b0;
                    dac_d    = NBITS'(1) << (NBITS - 1);
                    idx_d    = IW'(NBITS - 1);
                    req_d    = 1'b1;
                    state_d  = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMPARE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A valid decision beats a timeout landing in the same cycle.
                if (comp_valid_i) begin
                    decide  = 1'b1;
                    bit_val = comp_out_i;
                end else if (cnt_q == CW'(COMP_TIMEOUT - 1)) begin
                    decide  = 1'b1;
                    bit_val = 1'b0;
                    to_d    = 1'b1;
                end
                if (decide) begin
                    dac_d[idx_q] = bit_val;
                    if (idx_q != '0) begin
                        dac_d[idx_m1] = 1'b1;
                        idx_d         = idx_m1;
                        req_d         = 1'b1;
                        state_d       = S_COMPARE;
                    end else begin
                        res_d   = dac_d;
                        rv_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign comp_req_o         = req_q;
    assign sample_o           = sample_q;
    assign dac_state_o        = dac_q;
    assign dac_drive_invert_o = inv_q;
    assign busy_o             = busy_q;
    assign result_o           = res_q;
    assign result_valid_o     = rv_q;
    assign timeout_err_o      = to_q;

endmodule

// File: tb/tb_sar_logic.sv
// Bench for sar_logic: timing-based reference model checked every cycle, a
// scripted comparator, and directed conversions with hand-computed results.
module tb_sar_logic;

    localparam int NB = 16;
    localparam int SC = 2;
    localparam int CT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          invert_en = 1'b0;
    logic          comp_valid = 1'b0;
    logic          comp_out = 1'b0;
    logic          comp_req, sample, inv_o, busy, rv, to;
    logic [NB-1:0] dac, result;

    always #5 clk = ~clk;

    sar_logic #(.NBITS(NB), .SAMPLE_CYCLES(SC), .COMP_TIMEOUT(CT)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .invert_en_i(invert_en),
        .comp_req_o(comp_req), .comp_valid_i(comp_valid), .comp_out_i(comp_out),
        .sample_o(sample), .dac_state_o(dac), .dac_drive_invert_o(inv_o),
        .busy_o(busy), .result_o(result), .result_valid_o(rv), .timeout_err_o(to)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks time since acceptance and since each comparator
    // request, and applies the SAR rules directly to a code word.
    logic          m_busy = 0, m_sample = 0, m_req = 0, m_inv = 0, m_rv = 0, m_to = 0;
    logic [NB-1:0] m_dac = '0, m_res = '0;
    logic          m_on = 0, m_prev_rv, m_got;
    int            m_t = 0, m_age = 0, m_k = 0;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc++;
        m_on      = 1'b1;
        m_prev_rv = m_rv;
        m_rv      = 1'b0;
        m_req     = 1'b0;
        if (!rst_n) begin
            m_busy = 0; m_sample = 0; m_inv = 0; m_to = 0; m_dac = '0; m_res = '0;
        end else if (m_busy) begin
            m_t++;
            if (m_t == SC) begin
                m_sample = 0;
                m_k      = NB - 1;
                m_dac    = NB'(1) << m_k;
                m_req    = 1;
                m_age    = 0;
            end else if (m_t > SC) begin
                m_age++;
                m_got = comp_valid && (m_age >= 2);
                if (m_got || m_age == CT + 1) begin
                    if (!m_got) m_to = 1;
                    m_dac[m_k] = m_got ? comp_out : 1'b0;
                    if (m_k > 0) begin
                        m_k--;
                        m_dac[m_k] = 1'b1;
                        m_req      = 1;
                        m_age      = 0;
                    end else begin
                        m_res  = m_dac;
                        m_rv   = 1;
                        m_busy = 0;
                    end
                end
            end
        end else if (start && !m_prev_rv) begin
            m_busy = 1; m_sample = 1; m_inv = invert_en; m_dac = '0; m_to = 0; m_t = 0;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("comp_req", comp_req, m_req);
            chk("sample", sample, m_sample);
            chk("dac_state", dac, m_dac);
            chk("dac_drive_invert", inv_o, m_inv);
            chk("busy", busy, m_busy);
            chk("result", result, m_res);
            chk("result_valid", rv, m_rv);
            chk("timeout_err", to, m_to);
        end
    end

    // Scripted comparator. Modes: 0 keep-if-trial<=target, 1 always 1,
    // 2 always 0, 3 never answer, 4 like 0 but bit 7 answers 1 at timeout expiry.
    int            r_mode = 0;
    logic [NB-1:0] r_tgt = '0;
    int            r_pend = 0;
    logic          r_dec = 0;
    int            r_ntr = 0;
    logic [NB-1:0] r_trials[NB];

    always @(negedge clk) begin
        comp_valid = 1'b0;
        if (!rst_n) r_pend = 0;
        if (r_pend > 0) begin
            r_pend--;
            if (r_pend == 0) begin
                comp_valid = 1'b1;
                comp_out   = r_dec;
            end
        end
        if (comp_req === 1'b1) begin
            if (r_ntr < NB) r_trials[r_ntr] = dac;
            r_pend = 1;
            r_dec  = (dac <= r_tgt);
            case (r_mode)
                1: r_dec = 1'b1;
                2: r_dec = 1'b0;
                3: r_pend = 0;
                4: if (NB - 1 - r_ntr == 7) begin r_pend = CT; r_dec = 1'b1; end
                default: ;
            endcase
            r_ntr++;
        end
    end

    int t0 = 0;

    task automatic start_conv(input logic inv, input logic [NB-1:0] tgt, input int mode);
        r_mode = mode; r_tgt = tgt; r_ntr = 0;
        @(negedge clk); start = 1'b1; invert_en = inv;
        @(negedge clk); start = 1'b0; t0 = cyc;
    endtask

    task automatic wait_done(output int ncyc);
        int guard = 0;
        while (rv !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
        if (guard >= 1000) chk("done_timeout", 32'd0, 32'd1);
        ncyc = cyc - t0;
    endtask

    int n;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_dac", dac, 0);
        chk("rst_result", result, 0);
        chk("rst_sample", sample, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: nominal conversion with L=1
        start_conv(1'b0, 16'hA5C3, 0);
        wait_done(n);
        chk("t1_result", result, 32'hA5C3);
        chk("t1_latency", n, 34);
        chk("t1_busy", busy, 0);
        chk("t1_to", to, 0);
        @(negedge clk);

        // 2: all-ones and all-zeros decisions
        start_conv(1'b1, '0, 1);
        chk("t2_inv", inv_o, 1);
        wait_done(n);
        chk("t2_ones", result, 32'hFFFF);
        chk("t2_tr0", r_trials[0], 32'h8000);
        chk("t2_tr1", r_trials[1], 32'hC000);
        chk("t2_tr2", r_trials[2], 32'hE000);
        @(negedge clk);
        start_conv(1'b0, '0, 2);
        wait_done(n);
        chk("t2_zeros", result, 32'h0000);
        chk("t2_tr0z", r_trials[0], 32'h8000);
        chk("t2_tr1z", r_trials[1], 32'h4000);
        chk("t2_tr2z", r_trials[2], 32'h2000);
        @(negedge clk);

        // 3: comparator never answers
        start_conv(1'b0, '0, 3);
        wait_done(n);
        chk("t3_result", result, 0);
        chk("t3_to", to, 1);
        chk("t3_latency", n, 2 + 16 * (CT + 1));
        @(negedge clk);
        start_conv(1'b0, 16'h5A5A, 0);
        chk("t3_to_clr", to, 0);
        wait_done(n);
        chk("t3_result2", result, 32'h5A5A);
        @(negedge clk);

        // 4: valid coincident with timeout on bit 7
        start_conv(1'b0, 16'h3C96, 4);
        wait_done(n);
        chk("t4_result", result, 32'h3C96);
        chk("t4_to", to, 0);
        chk("t4_latency", n, 2 + 15 * 2 + CT + 1);
        @(negedge clk);

        // 5: start while busy and start in the result_valid cycle are ignored
        start_conv(1'b0, 16'h0F0F, 0);
        repeat (5) @(negedge clk);
        start = 1'b1; invert_en = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t5_inv_hold", inv_o, 0);
        wait_done(n);
        chk("t5_latency", n, 34);
        chk("t5_result", result, 32'h0F0F);
        start = 1'b1; invert_en = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("t5_rv_start_ign", busy, 0);
        start_conv(1'b1, 16'h00FF, 0);
        chk("t5_inv_new", inv_o, 1);
        wait_done(n);
        chk("t5_result2", result, 32'h00FF);
        @(negedge clk);

        // 6: reset during bit 9, then a clean conversion
        start_conv(1'b1, 16'hBEEF, 0);
        n = 0;
        while (r_ntr < 7 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("t6_wait", 32'd0, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_dac", dac, 0);
        chk("t6_inv", inv_o, 0);
        chk("t6_result", result, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_no_rv", busy, 0);
        start_conv(1'b0, 16'h1234, 0);
        wait_done(n);
        chk("t6_result2", result, 32'h1234);
        chk("t6_latency", n, 34);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
